seg_display_arbiter: RTL and testbench

//   Shares the single 7-segment digit display (seg7 decoder + digit path) among
//   NUM_REQ requesters. Round-robin grants, each owner holds the display for a

---
 rtl/display_arb_pkg.sv | 27 ++
 rtl/seg_display_arbiter_picker.sv | 39 +++
 rtl/seg_display_arbiter.sv | 147 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_arb_pkg : shared types and constants for the 7-segment arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
package display_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int DIGIT_W    = 4;
  localparam int CNT_W      = 24;
  localparam int HOLD_SHIFT = 10;

  // Nonzero selector scales by 2^HOLD_SHIFT; zero falls back to the default dwell.
  function automatic logic [CNT_W-1:0] dwell_limit(input logic [7:0]       sel,
                                                   input logic [CNT_W-1:0] dflt);
    if (sel != 8'd0)
      return {{(CNT_W-8-HOLD_SHIFT){1'b0}}, sel, {HOLD_SHIFT{1'b0}}};
    return dflt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_arbiter_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_priority_picker : first active request at or after ptr, searching cyclically
// Revision 1.0
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int               j;
  logic [IDX_W-1:0] j_idx;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    j_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = IDX_W'(j);
      if (!valid && req[j_idx]) begin
        valid         = 1'b1;
        onehot[j_idx] = 1'b1;
        idx           = j_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_display_arbiter : round-robin sharing of one 7-segment digit with dwell + gap
// Revision 1.0
// ---------------------------------------------------------------------------
module seg_display_arbiter
  import display_arb_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter logic [23:0] HOLD_CYCLES = 24'd10_000_000,
  parameter logic [23:0] GAP_CYCLES  = 24'd100_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [DIGIT_W*NUM_REQ-1:0] req_digit,
  input  logic [7:0]                 hold_sel,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [DIGIT_W-1:0]         disp_digit,
  output logic                       disp_blank,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               blank_q, blank_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   limit_q, limit_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [DIGIT_W-1:0] owner_digit;
  logic [IDX_W-1:0]   ptr_after_owner;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    owner_digit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) owner_digit = req_digit[i*DIGIT_W +: DIGIT_W];
    end
  end

  assign ptr_after_owner = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    digit_d = digit_q;
    blank_d = blank_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = HOLD;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          cnt_d   = '0;
          limit_d = dwell_limit(hold_sel, HOLD_CYCLES);
          blank_d = 1'b0;
        end
      end
      HOLD: begin
        // Expiry takes precedence so a release on the last cycle still earns done.
        if (cnt_q == limit_q || !req[owner_q]) begin
          if (cnt_q == limit_q) done_d = grant_q;
          state_d = (GAP_CYCLES == '0) ? IDLE : GAP;
          grant_d = '0;
          blank_d = 1'b1;
          cnt_d   = '0;
          ptr_d   = ptr_after_owner;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          digit_d = owner_digit;
        end
      end
      GAP: begin
        if (cnt_q == GAP_CYCLES - 24'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        blank_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      digit_q <= '0;
      blank_q <= 1'b1;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign disp_digit = digit_q;
  assign disp_blank = blank_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_display_arbiter : directed self-checking bench, NUM_REQ=4 HOLD=8 GAP=2
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_digit = '0;
  logic [7:0]  hold_sel = '0;
  logic [3:0]  grant, done, disp_digit;
  logic        disp_blank, busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg_display_arbiter #(
    .NUM_REQ     (4),
    .HOLD_CYCLES (24'd8),
    .GAP_CYCLES  (24'd2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_digit  (req_digit),
    .hold_sel   (hold_sel),
    .grant      (grant),
    .done       (done),
    .disp_digit (disp_digit),
    .disp_blank (disp_blank),
    .busy       (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req   = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle timeout: busy=%b want 0", tag, busy);
    end
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({grant, done, disp_digit, disp_blank, busy} !== {4'b0, 4'b0, 4'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: grant=%b done=%b digit=%h blank=%b busy=%b want 0000 0000 0 1 0",
               grant, done, disp_digit, disp_blank, busy);
    end
  endtask

  task automatic test_single;
    int n, m;
    do_reset();
    req_digit = 16'h0700;
    req = 4'b0100;
    step();
    total++;
    if (grant !== 4'b0100 || disp_blank !== 1'b0 || disp_digit !== 4'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: grant=%b blank=%b digit=%h busy=%b want 0100 0 0 1",
               grant, disp_blank, disp_digit, busy);
    end
    n = 0;
    while (grant !== 4'b0000 && n < 50) begin
      n++;
      step();
      if (n == 1) begin
        total++;
        if (disp_digit !== 4'd7) begin
          bad++;
          $display("FAIL single_digit: digit=%h want 7", disp_digit);
        end
      end
    end
    total++;
    if (n != 9) begin
      bad++;
      $display("FAIL single_dwell: cycles=%0d want 9", n);
    end
    total++;
    if (done !== 4'b0100 || disp_blank !== 1'b1 || disp_digit !== 4'd7) begin
      bad++;
      $display("FAIL single_done: done=%b blank=%b digit=%h want 0100 1 7", done, disp_blank, disp_digit);
    end
    m = 1;
    step();
    total++;
    if (done !== 4'b0000) begin
      bad++;
      $display("FAIL single_done_pulse: done=%b want 0000", done);
    end
    while (grant === 4'b0000 && m < 50) begin
      m++;
      step();
    end
    total++;
    if (m != 3 || grant !== 4'b0100) begin
      bad++;
      $display("FAIL single_regrant: gap=%0d grant=%b want 3 0100", m, grant);
    end
    req = 4'b0000;
    step();
    total++;
    if (grant !== 4'b0000 || done !== 4'b0000) begin
      bad++;
      $display("FAIL single_release: grant=%b done=%b want 0000 0000", grant, done);
    end
    wait_idle("single");
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_digit [5] = '{4'hA, 4'h3, 4'h7, 4'hF, 4'hA};
    int n;
    do_reset();
    req_digit = 16'hF73A;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (grant === 4'b0000 && n < 20) begin
        step();
        n++;
      end
      total++;
      if (grant !== exp_order[g]) begin
        bad++;
        $display("FAIL rr_order[%0d]: grant=%b want %b", g, grant, exp_order[g]);
      end
      step();
      total++;
      if (disp_digit !== exp_digit[g]) begin
        bad++;
        $display("FAIL rr_digit[%0d]: digit=%h want %h", g, disp_digit, exp_digit[g]);
      end
      n = 0;
      while (grant !== 4'b0000 && n < 20) begin
        total++;
        if (grant !== exp_order[g]) begin
          bad++;
          $display("FAIL rr_stable[%0d]: grant=%b want %b", g, grant, exp_order[g]);
        end
        step();
        n++;
      end
    end
    req = 4'b0000;
    wait_idle("rr");
  endtask

  task automatic test_early_release;
    do_reset();
    req = 4'b0010;
    step();
    step();
    step();
    req = 4'b0000;
    step();
    total++;
    if (grant !== 4'b0000 || done !== 4'b0000 || disp_blank !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL early_release: grant=%b done=%b blank=%b busy=%b want 0000 0000 1 1",
               grant, done, disp_blank, busy);
    end
    step();
    total++;
    if (busy !== 1'b1 || done !== 4'b0000) begin
      bad++;
      $display("FAIL early_gap: busy=%b done=%b want 1 0000", busy, done);
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL early_gap_end: busy=%b want 0", busy);
    end
  endtask

  task automatic test_hold_sel;
    int n;
    do_reset();
    hold_sel = 8'd1;
    req = 4'b0001;
    step();
    n = 0;
    while (grant !== 4'b0000 && n < 2000) begin
      if (n == 5) hold_sel = 8'd0;
      n++;
      step();
    end
    total++;
    if (n != 1025 || done !== 4'b0001) begin
      bad++;
      $display("FAIL hold_sel_dwell: cycles=%0d done=%b want 1025 0001", n, done);
    end
    req = 4'b0000;
    hold_sel = 8'd0;
    wait_idle("hold_sel");
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset();
    req = 4'b0010;
    step();
    n = 0;
    while (grant !== 4'b0000 && n < 20) begin
      n++;
      step();
    end
    req = 4'b0000;
    wait_idle("reset_mid_pre");
    req = 4'b0100;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    total++;
    if (grant !== 4'b0000 || disp_blank !== 1'b1 || done !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: grant=%b blank=%b done=%b busy=%b want 0000 1 0000 0",
               grant, disp_blank, done, busy);
    end
    reset = 1'b0;
    req = 4'b0110;
    step();
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL reset_ptr: grant=%b want 0010", grant);
    end
    req = 4'b0000;
    wait_idle("reset_mid");
  endtask

  task automatic test_release_on_expiry;
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 9; k++) step();
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL expiry_last: grant=%b want 0001", grant);
    end
    req = 4'b0000;
    step();
    total++;
    if (grant !== 4'b0000 || done !== 4'b0001) begin
      bad++;
      $display("FAIL expiry_release: grant=%b done=%b want 0000 0001", grant, done);
    end
    wait_idle("expiry");
    req = 4'b0011;
    step();
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL expiry_ptr: grant=%b want 0010", grant);
    end
    req = 4'b0000;
    wait_idle("expiry_post");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_hold_sel();
    test_reset_mid();
    test_release_on_expiry();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
